// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: tick-sampled glitch filter, frame FSM with parity/stop/timeout
// checks, optional E0/F0 prefix folding, and a first-word-fall-through output FIFO.
module ps2_rx_fifo #(
  parameter int unsigned CLK_DIV = 250,
  parameter int unsigned FILTER  = 3,
  parameter int unsigned TIMEOUT = 4000,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned DECODE  = 1
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     PS2_CLK,
  input  logic                     PS2_DATA,
  input  logic                     RD_EN,
  output logic [9:0]               RD_DATA,
  output logic                     EMPTY,
  output logic                     FULL,
  output logic [$clog2(DEPTH):0]   LEVEL,
  output logic                     ERR_PARITY,
  output logic                     ERR_FRAME,
  output logic                     OVERFLOW
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LW    = AW + 1;
  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned FLT_W = $clog2(FILTER + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CHECK} state_t;

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [1:0]       clk_sync;
  logic [1:0]       dat_sync;
  logic             filt_clk;
  logic [FLT_W-1:0] filt_cnt;
  logic             flt_flip;
  logic             bit_edge;
  state_t           state;
  logic [9:0]       shreg;
  logic [3:0]       bit_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             ext_pend;
  logic             rel_pend;
  logic             push_req;
  logic [9:0]       push_data;
  logic [9:0]       mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;
  logic             do_push;
  logic [LW-1:0]    level_nxt;

  // Sample-tick divider
  assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) div_cnt <= '0;
    else        div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
  end

  // Synchronisers and tick-based clock filter; a flip needs FILTER consecutive differing samples
  assign flt_flip = tick && (clk_sync[1] != filt_clk) && (filt_cnt == FLT_W'(FILTER - 1));
  assign bit_edge = flt_flip && filt_clk;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else begin
      clk_sync <= {clk_sync[0], PS2_CLK};
      dat_sync <= {dat_sync[0], PS2_DATA};
      if (tick) begin
        if (clk_sync[1] == filt_clk) begin
          filt_cnt <= '0;
        end else if (flt_flip) begin
          filt_clk <= clk_sync[1];
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + FLT_W'(1);
        end
      end
    end
  end

  // Frame FSM; shreg ends as {stop, parity, data[7:0]}
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= S_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      to_cnt     <= '0;
      ext_pend   <= 1'b0;
      rel_pend   <= 1'b0;
      push_req   <= 1'b0;
      push_data  <= '0;
      ERR_PARITY <= 1'b0;
      ERR_FRAME  <= 1'b0;
    end else begin
      ERR_PARITY <= 1'b0;
      ERR_FRAME  <= 1'b0;
      push_req   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bit_edge && !dat_sync[1]) begin
            state   <= S_SHIFT;
            bit_cnt <= '0;
            to_cnt  <= '0;
          end
        end
        S_SHIFT: begin
          if (bit_edge) begin
            shreg  <= {dat_sync[1], shreg[9:1]};
            to_cnt <= '0;
            if (bit_cnt == 4'd9) state <= S_CHECK;
            else                 bit_cnt <= bit_cnt + 4'd1;
          end else if (tick) begin
            if (to_cnt == TO_W'(TIMEOUT - 1)) begin
              state     <= S_IDLE;
              ERR_FRAME <= 1'b1;
              ext_pend  <= 1'b0;
              rel_pend  <= 1'b0;
              to_cnt    <= '0;
              bit_cnt   <= '0;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end
        end
        S_CHECK: begin
          state   <= S_IDLE;
          bit_cnt <= '0;
          to_cnt  <= '0;
          if (!shreg[9]) begin
            ERR_FRAME <= 1'b1;
            ext_pend  <= 1'b0;
            rel_pend  <= 1'b0;
          end else if (!(^shreg[8:0])) begin
            ERR_PARITY <= 1'b1;
            ext_pend   <= 1'b0;
            rel_pend   <= 1'b0;
          end else if ((DECODE != 0) && (shreg[7:0] == 8'hE0)) begin
            ext_pend <= 1'b1;
          end else if ((DECODE != 0) && (shreg[7:0] == 8'hF0)) begin
            rel_pend <= 1'b1;
          end else begin
            push_req  <= 1'b1;
            push_data <= {ext_pend, rel_pend, shreg[7:0]};
            ext_pend  <= 1'b0;
            rel_pend  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output FIFO; a push into a full FIFO succeeds only when a pop frees a slot the same cycle
  assign do_pop  = RD_EN && !EMPTY;
  assign do_push = push_req && (!FULL || do_pop);
  assign RD_DATA = mem[rd_ptr];

  always_comb begin
    level_nxt = LEVEL;
    if (do_push && !do_pop)      level_nxt = LEVEL + LW'(1);
    else if (!do_push && do_pop) level_nxt = LEVEL - LW'(1);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[AW'(i)] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      LEVEL    <= '0;
      EMPTY    <= 1'b1;
      FULL     <= 1'b0;
      OVERFLOW <= 1'b0;
    end else begin
      OVERFLOW <= push_req && FULL && !do_pop;
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      LEVEL <= level_nxt;
      EMPTY <= (level_nxt == '0);
      FULL  <= (level_nxt == LW'(DEPTH));
    end
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench: two receivers (prefix-folding and raw) share one PS/2 line; a keyboard
// model predicts entries into queues that a monitor drains and compares.
module tb_ps2_rx_fifo;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned FILTER  = 3;
  localparam int unsigned TIMEOUT = 40;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned LW      = $clog2(DEPTH) + 1;
  localparam int          HALF    = 32;

  logic          clk = 1'b0;
  logic          rst_n, ps2_clk, ps2_data;
  logic          rd_en0, rd_en1;
  logic [9:0]    rd_data0, rd_data1;
  logic          empty0, empty1, full0, full1;
  logic [LW-1:0] level0, level1;
  logic          err_par0, err_par1, err_frm0, err_frm1, ovf0, ovf1;

  always #5 clk = ~clk;

  ps2_rx_fifo #(.CLK_DIV(CLK_DIV), .FILTER(FILTER), .TIMEOUT(TIMEOUT), .DEPTH(DEPTH), .DECODE(1)) u_dec (
    .CLK(clk), .RST_N(rst_n), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data), .RD_EN(rd_en0),
    .RD_DATA(rd_data0), .EMPTY(empty0), .FULL(full0), .LEVEL(level0),
    .ERR_PARITY(err_par0), .ERR_FRAME(err_frm0), .OVERFLOW(ovf0));

  ps2_rx_fifo #(.CLK_DIV(CLK_DIV), .FILTER(FILTER), .TIMEOUT(TIMEOUT), .DEPTH(DEPTH), .DECODE(0)) u_raw (
    .CLK(clk), .RST_N(rst_n), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data), .RD_EN(rd_en1),
    .RD_DATA(rd_data1), .EMPTY(empty1), .FULL(full1), .LEVEL(level1),
    .ERR_PARITY(err_par1), .ERR_FRAME(err_frm1), .OVERFLOW(ovf1));

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0] q0[$];
  logic [9:0] q1[$];
  bit ext1 = 1'b0, rel1 = 1'b0;
  bit rd_on = 1'b0;
  int exp_par = 0, exp_frm = 0, exp_ovf0 = 0, exp_ovf1 = 0;
  int cnt_par0 = 0, cnt_par1 = 0, cnt_frm0 = 0, cnt_frm1 = 0, cnt_ovf0 = 0, cnt_ovf1 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Pulse counters
  always @(negedge clk) begin
    if (err_par0) cnt_par0++;
    if (err_par1) cnt_par1++;
    if (err_frm0) cnt_frm0++;
    if (err_frm1) cnt_frm1++;
    if (ovf0)     cnt_ovf0++;
    if (ovf1)     cnt_ovf1++;
  end

  // Monitor: pop whatever the receivers present and compare against the scoreboard
  initial begin
    rd_en0 = 1'b0;
    rd_en1 = 1'b0;
    forever begin
      @(negedge clk);
      rd_en0 = 1'b0;
      rd_en1 = 1'b0;
      if (rd_on && rst_n) begin
        if (!empty0) begin
          if (q0.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL dec_unexpected: got 0x%0h, expected no entry", rd_data0);
          end else check("dec_head", rd_data0, q0.pop_front());
          rd_en0 = 1'b1;
        end
        if (!empty1) begin
          if (q1.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL raw_unexpected: got 0x%0h, expected no entry", rd_data1);
          end else check("raw_head", rd_data1, q1.pop_front());
          rd_en1 = 1'b1;
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] mk(input logic [7:0] b, input bit bad);
    logic p;
    p = ~(^b) ^ bad;
    return {1'b1, p, b, 1'b0};
  endfunction

  // Keyboard side: data changes while the clock is high, glitch_bit inserts a short low pulse
  task automatic send_frame(input logic [10:0] fr, input int nbits, input int glitch_bit);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      if (i == glitch_bit) begin
        wait_clk(HALF / 2);
        ps2_clk = 1'b0;
        wait_clk((FILTER - 1) * CLK_DIV);
        ps2_clk = 1'b1;
        wait_clk(HALF / 2 - (FILTER - 1) * CLK_DIV);
      end else begin
        wait_clk(HALF);
      end
      ps2_clk = 1'b0;
      wait_clk(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_clk(4 * HALF);
  endtask

  task automatic mpush0(input logic [9:0] v);
    if (q0.size() >= DEPTH) exp_ovf0++;
    else q0.push_back(v);
  endtask

  task automatic mpush1(input logic [9:0] v);
    if (q1.size() >= DEPTH) exp_ovf1++;
    else q1.push_back(v);
  endtask

  // Reference keyboard-protocol model
  task automatic model_byte(input logic [7:0] b, input bit bad);
    if (bad) begin
      exp_par++;
      ext1 = 1'b0;
      rel1 = 1'b0;
    end else begin
      mpush1({2'b00, b});
      if (b == 8'hE0)      ext1 = 1'b1;
      else if (b == 8'hF0) rel1 = 1'b1;
      else begin
        mpush0({ext1, rel1, b});
        ext1 = 1'b0;
        rel1 = 1'b0;
      end
    end
  endtask

  task automatic tx(input logic [7:0] b, input bit bad, input int glitch_bit);
    model_byte(b, bad);
    send_frame(mk(b, bad), 11, glitch_bit);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || !empty0 || !empty1) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_pending"}, 32'(q0.size() + q1.size()), 32'd0);
  endtask

  task automatic check_errs(input string name);
    check({name, "_err_par_dec"}, cnt_par0, exp_par);
    check({name, "_err_par_raw"}, cnt_par1, exp_par);
    check({name, "_err_frm_dec"}, cnt_frm0, exp_frm);
    check({name, "_err_frm_raw"}, cnt_frm1, exp_frm);
    check({name, "_ovf_dec"}, cnt_ovf0, exp_ovf0);
    check({name, "_ovf_raw"}, cnt_ovf1, exp_ovf1);
  endtask

  task automatic check_reset(input string name);
    check({name, "_empty"}, {empty1, empty0}, 2'b11);
    check({name, "_full"}, {full1, full0}, 2'b00);
    check({name, "_level"}, {level1, level0}, '0);
    check({name, "_rd_data"}, {rd_data1, rd_data0}, '0);
    check({name, "_pulses"}, {err_par0, err_par1, err_frm0, err_frm1, ovf0, ovf1}, '0);
  endtask

  initial begin
    logic [7:0] b;
    bit bad;
    rst_n    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_clk(5);
    check_reset("reset");
    rst_n = 1'b1;
    wait_clk(10);

    // Single byte held in the FIFO, then read out
    tx(8'h75, 1'b0, -1);
    check("single_level_dec", level0, 1);
    check("single_level_raw", level1, 1);
    check("single_head_dec", rd_data0, q0[0]);
    check("single_head_raw", rd_data1, q1[0]);
    check_errs("single");
    rd_on = 1'b1;
    drain("single");
    check("single_empty_after_read", {empty1, empty0}, 2'b11);

    // Extended release sequence
    tx(8'hE0, 1'b0, -1);
    tx(8'hF0, 1'b0, -1);
    tx(8'h74, 1'b0, -1);
    drain("prefix");
    check_errs("prefix");

    // Parity error then a good byte
    tx(8'h1C, 1'b1, -1);
    check("parity_empty", {empty1, empty0}, 2'b11);
    tx(8'h1C, 1'b0, -1);
    drain("parity");
    check_errs("parity");

    // Truncated frame aborted by timeout, then recovery
    exp_frm++;
    ext1 = 1'b0;
    rel1 = 1'b0;
    send_frame(mk(8'h33, 1'b0), 5, -1);
    wait_clk((TIMEOUT + 8) * CLK_DIV);
    check_errs("timeout");
    tx(8'h72, 1'b0, -1);
    drain("timeout_next");

    // Short clock glitch inside a frame
    tx(8'h5A, 1'b0, 3);
    drain("glitch");
    check_errs("glitch");

    // Random byte stream with prefixes and occasional parity errors
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 3) == 0) b = ($urandom_range(0, 1) == 0) ? 8'hE0 : 8'hF0;
      else b = 8'($urandom);
      bad = ($urandom_range(0, 7) == 0);
      tx(b, bad, -1);
    end
    drain("random");
    check_errs("random");

    // Fill past capacity with no reads
    rd_on = 1'b0;
    wait_clk(4);
    for (int i = 1; i <= 9; i++) tx(8'(i), 1'b0, -1);
    check("ovf_full", {full1, full0}, 2'b11);
    check("ovf_level_dec", level0, DEPTH);
    check("ovf_level_raw", level1, DEPTH);
    check_errs("ovf");
    rd_on = 1'b1;
    drain("ovf");

    // Reset in the middle of a frame
    send_frame(mk(8'h44, 1'b0), 4, -1);
    rst_n = 1'b0;
    ext1  = 1'b0;
    rel1  = 1'b0;
    wait_clk(3);
    check_reset("midreset");
    rst_n = 1'b1;
    wait_clk(HALF);
    tx(8'h29, 1'b0, -1);
    drain("midreset");
    check_errs("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
